// File: rtl/datapath_sequencer.sv
// Purpose: micro-programmed controller for the 8-bit ALU/accumulator datapath.
//          It drives {s2,s1,s0,f2,f1,f0} one instruction per clock and reports
//          completion through busy/done/ovf_err/steps.
// Latency: start sampled at edge k -> instruction 0 is driven in cycle k+1.
//          An N-instruction run holds busy for N cycles, and done pulses in cycle k+N+1.
// Backpressure: none. start is ignored in RUN and DONE. Program writes are ignored in RUN.
//
// Ports:
//   clk, reset             rising-edge clock; synchronous active-high reset
//   start                  1-cycle pulse that runs the program from address 0
//   prog_we/addr/data      program write port; instruction {END,OVF_STOP,LD,SRC[1:0],FN[2:0]}
//   ovf                    datapath overflow for the word currently driven
//   s2,s1,s0,f2,f1,f0      datapath select/load/function lines
//   busy, done, ovf_err    run status; steps = instructions executed by the last/current run
module datapath_sequencer #(
    parameter int          AW        = 3,
    parameter logic [5:0]  HOLD_WORD = 6'b000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          ovf,
    output logic          s2,
    output logic          s1,
    output logic          s0,
    output logic          f2,
    output logic          f1,
    output logic          f0,
    output logic          busy,
    output logic          done,
    output logic          ovf_err,
    output logic [AW:0]   steps
);

    localparam int            DEPTH     = 1 << AW;
    localparam logic [AW-1:0] PC_LAST   = {AW{1'b1}};
    localparam logic [AW:0]   STEPS_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   steps_q, steps_d;
    logic          ovf_err_q, ovf_err_d;

    logic [7:0]    prog_q [DEPTH];

    // Instruction fields of the entry at pc.
    logic [7:0]    instr;
    logic          inst_end;
    logic          inst_ovf_stop;
    logic          inst_ld;
    logic [1:0]    inst_src;
    logic [2:0]    inst_fn;

    logic          prog_wr_en;
    logic [5:0]    ctrl_word;

    assign instr         = prog_q[pc_q];
    assign inst_end      = instr[7];
    assign inst_ovf_stop = instr[6];
    assign inst_ld       = instr[5];
    assign inst_src      = instr[4:3];
    assign inst_fn       = instr[2:0];

    // Writes land in IDLE and DONE. A write on the same edge as start in IDLE
    // is committed before instruction 0 is read in the following cycle.
    assign prog_wr_en = prog_we && (state_q != ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                prog_q[i] <= 8'h00;
            end
        end else if (prog_wr_en) begin
            prog_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            steps_q   <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            steps_q   <= steps_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        steps_d   = steps_q;
        ovf_err_d = ovf_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    pc_d      = '0;
                    steps_d   = '0;
                    ovf_err_d = 1'b0;
                end
            end

            ST_RUN: begin
                // pc never wraps, so steps cannot exceed DEPTH; the guard keeps
                // the counter pinned even if that invariant were ever broken.
                if (steps_q != STEPS_MAX) begin
                    steps_d = steps_q + 1'b1;
                end
                // ovf is only examined for OVF_STOP words, at the edge ending that word.
                if (inst_ovf_stop && ovf) begin
                    state_d   = ST_DONE;
                    ovf_err_d = 1'b1;
                end else if (inst_end || (pc_q == PC_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRC 10 and 11 both select d.
    always_comb begin
        ctrl_word = HOLD_WORD;
        if (state_q == ST_RUN) begin
            ctrl_word = {inst_src[1], (inst_src == 2'b01), inst_ld, inst_fn};
        end
    end

    assign s2      = ctrl_word[5];
    assign s1      = ctrl_word[4];
    assign s0      = ctrl_word[3];
    assign f2      = ctrl_word[2];
    assign f1      = ctrl_word[1];
    assign f0      = ctrl_word[0];

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign ovf_err = ovf_err_q;
    assign steps   = steps_q;

endmodule
